// File: rtl/cache_mem_arbiter.sv
// 2-to-1 Avalon arbiter between the icache (m0) and dcache (m1) and the single memory bus.
// Zero-latency grant when idle, grant held across waitrequest, read data routed by owner.
package cache_mem_arbiter_pkg;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [3:0]  byte_enable;
    logic [31:0] writedata;
  } avalon_req_t;

  typedef struct packed {
    logic [31:0] readdata;
    logic        waitrequest;
  } avalon_resp_t;

endpackage

module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  avalon_req_t  m0_avn_req,
  output avalon_resp_t m0_avn_resp,
  input  avalon_req_t  m1_avn_req,
  output avalon_resp_t m1_avn_resp,
  output avalon_req_t  mem_avn_req,
  input  avalon_resp_t mem_avn_resp
);

  typedef enum logic [1:0] {StIdle, StLock0, StLock1} state_e;

  state_e state_q, state_d;
  logic   rr_ptr_q;
  logic   rd_owner_q;
  logic   rd_owner_vld_q;

  logic req0, req1;
  logic grant_vld, grant;
  logic xfer_req, xfer_done;

  always_comb begin
    req0      = m0_avn_req.read | m0_avn_req.write;
    req1      = m1_avn_req.read | m1_avn_req.write;
    grant_vld = 1'b0;
    grant     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req0 && req1) begin
          grant_vld = 1'b1;
          grant     = ROUND_ROBIN ? rr_ptr_q : 1'b1;
        end else if (req0 || req1) begin
          grant_vld = 1'b1;
          grant     = req1;
        end
      end
      StLock0: begin
        grant_vld = 1'b1;
        grant     = 1'b0;
      end
      StLock1: begin
        grant_vld = 1'b1;
        grant     = 1'b1;
      end
      default: ;
    endcase

    if (rst) grant_vld = 1'b0;

    // Address/data follow m0 when nothing is granted; only the strobes are forced low.
    mem_avn_req = (grant_vld && grant) ? m1_avn_req : m0_avn_req;
    if (!grant_vld) begin
      mem_avn_req.read  = 1'b0;
      mem_avn_req.write = 1'b0;
    end

    xfer_req  = mem_avn_req.read | mem_avn_req.write;
    xfer_done = xfer_req & ~mem_avn_resp.waitrequest;

    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (xfer_req && mem_avn_resp.waitrequest) state_d = grant ? StLock1 : StLock0;
      end
      // A locked master dropping its strobes also releases the lock.
      StLock0, StLock1: begin
        if (xfer_done || !xfer_req) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    m0_avn_resp.waitrequest = ~(grant_vld & ~grant) | mem_avn_resp.waitrequest;
    m1_avn_resp.waitrequest = ~(grant_vld & grant) | mem_avn_resp.waitrequest;
    m0_avn_resp.readdata    = (!rst && rd_owner_vld_q && !rd_owner_q) ?
                              mem_avn_resp.readdata : 32'h0;
    m1_avn_resp.readdata    = (!rst && rd_owner_vld_q && rd_owner_q) ?
                              mem_avn_resp.readdata : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      rr_ptr_q       <= 1'b0;
      rd_owner_q     <= 1'b0;
      rd_owner_vld_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_owner_vld_q <= xfer_done & mem_avn_req.read;
      if (xfer_done) rr_ptr_q <= ~grant;
      if (xfer_done && mem_avn_req.read) rd_owner_q <= grant;
    end
  end

endmodule
